// File: rtl/incrementor_pkg.sv
// Shared widths and address/step types for the DMA address incrementor.
package incrementor_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned STEP_W    = 16;
  localparam int unsigned PAGE_BITS = 12;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [STEP_W-1:0] step_t;

endpackage

// File: rtl/incr_adder.sv
// Combinational ADDR_W+1-bit adder: address plus zero-extended step.
// Kept separate so a carry-select variant can be dropped in.
module incr_adder
  import incrementor_pkg::*;
#(
  parameter int unsigned ADDR_W = incrementor_pkg::ADDR_W,
  parameter int unsigned STEP_W = incrementor_pkg::STEP_W
) (
  input  logic [ADDR_W-1:0] address,
  input  logic [STEP_W-1:0] step,
  output logic [ADDR_W-1:0] sum,
  output logic              carry
);

  logic [ADDR_W:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, address} + {{(ADDR_W + 1 - STEP_W){1'b0}}, step};
    sum      = wide_sum[ADDR_W-1:0];
    carry    = wide_sum[ADDR_W];
  end

endmodule

// File: rtl/incrementor.sv
// Registered address incrementor: one-cycle latency, reports address-space
// wrap and page crossing so burst logic can split transfers.
module incrementor
  import incrementor_pkg::*;
#(
  parameter int unsigned ADDR_W    = incrementor_pkg::ADDR_W,
  parameter int unsigned STEP_W    = incrementor_pkg::STEP_W,
  parameter int unsigned PAGE_BITS = incrementor_pkg::PAGE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [STEP_W-1:0] in_step,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_address,
  output logic              out_wrap,
  output logic              out_page_cross
);

  logic [ADDR_W-1:0] sum;
  logic              carry;
  logic              page_cross;

  incr_adder #(
    .ADDR_W (ADDR_W),
    .STEP_W (STEP_W)
  ) u_adder (
    .address (in_address),
    .step    (in_step),
    .sum     (sum),
    .carry   (carry)
  );

  // A wrap always lands in a different page even if the page fields match.
  always_comb begin
    page_cross = (sum[ADDR_W-1:PAGE_BITS] != in_address[ADDR_W-1:PAGE_BITS]) | carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_address    <= '0;
      out_wrap       <= 1'b0;
      out_page_cross <= 1'b0;
    end else if (in_valid) begin
      out_valid      <= 1'b1;
      out_address    <= sum;
      out_wrap       <= carry;
      out_page_cross <= page_cross;
    end else begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_incrementor.sv
// Self-checking bench for incrementor: directed cases with literal results
// plus randomized traffic checked each cycle against an arithmetic model.
module tb_incrementor;
  import incrementor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_address = '0;
  logic [15:0] in_step = '0;
  logic        out_valid;
  logic [31:0] out_address;
  logic        out_wrap;
  logic        out_page_cross;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference state
  logic        m_valid = 1'b0;
  logic [31:0] m_addr  = '0;
  logic        m_wrap  = 1'b0;
  logic        m_cross = 1'b0;

  incrementor #(
    .ADDR_W    (32),
    .STEP_W    (16),
    .PAGE_BITS (12)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_address     (in_address),
    .in_step        (in_step),
    .out_valid      (out_valid),
    .out_address    (out_address),
    .out_wrap       (out_wrap),
    .out_page_cross (out_page_cross)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] full_sum(logic [31:0] a, logic [15:0] s);
    return 64'(a) + 64'(s);
  endfunction

  // Model: plain integer arithmetic, pages identified by division by 4096.
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_wrap  <= 1'b0;
      m_cross <= 1'b0;
    end else if (in_valid) begin
      m_valid <= 1'b1;
      m_addr  <= 32'(full_sum(in_address, in_step));
      m_wrap  <= full_sum(in_address, in_step) >= 64'h1_0000_0000;
      m_cross <= (full_sum(in_address, in_step) >= 64'h1_0000_0000) ||
                 ((32'(full_sum(in_address, in_step)) / 32'd4096) != (in_address / 32'd4096));
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if ({out_valid, out_address, out_wrap, out_page_cross} !== {m_valid, m_addr, m_wrap, m_cross}) begin
        errors++;
        $display("FAIL model_cmp @%0t: got v=%0b a=%h w=%0b c=%0b, expected v=%0b a=%h w=%0b c=%0b",
                 $time, out_valid, out_address, out_wrap, out_page_cross,
                 m_valid, m_addr, m_wrap, m_cross);
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [15:0] s);
    @(negedge clk);
    rst        = r;
    in_valid   = v;
    in_address = a;
    in_step    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] a,
                            input logic w, input logic c);
    checks++;
    if ({out_valid, out_address, out_wrap, out_page_cross} !== {v, a, w, c}) begin
      errors++;
      $display("FAIL %s: got v=%0b a=%h w=%0b c=%0b, expected v=%0b a=%h w=%0b c=%0b",
               name, out_valid, out_address, out_wrap, out_page_cross, v, a, w, c);
    end
    checks++;
    if ({m_valid, m_addr, m_wrap, m_cross} !== {v, a, w, c}) begin
      errors++;
      $display("FAIL %s_model: got v=%0b a=%h w=%0b c=%0b, expected v=%0b a=%h w=%0b c=%0b",
               name, m_valid, m_addr, m_wrap, m_cross, v, a, w, c);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [15:0] s;

    // Reset held for two clocks while input is valid
    drive(1, 1, 32'h1234_5678, 16'd1);
    check_en = 1'b1;
    expect_out("reset_1", 0, 32'h0, 0, 0);
    drive(1, 1, 32'h1234_5678, 16'd1);
    expect_out("reset_2", 0, 32'h0, 0, 0);
    drive(0, 1, 32'h1234_5678, 16'd1);
    expect_out("first_after_reset", 1, 32'h1234_5679, 0, 0);

    // Back-to-back +1
    drive(0, 1, 32'h0000_0000, 16'd1);
    expect_out("inc_zero", 1, 32'h0000_0001, 0, 0);
    drive(0, 1, 32'hF0F0_F0F0, 16'd1);
    expect_out("inc_f0", 1, 32'hF0F0_F0F1, 0, 0);
    drive(0, 1, 32'hFFFF_FFFF, 16'd1);
    expect_out("inc_wrap", 1, 32'h0000_0000, 1, 1);

    // Page boundary
    drive(0, 1, 32'h0000_0FFF, 16'd1);
    expect_out("page_cross", 1, 32'h0000_1000, 0, 1);
    drive(0, 1, 32'h0000_1000, 16'h0FFF);
    expect_out("page_end", 1, 32'h0000_1FFF, 0, 0);

    // Zero step, then idle hold
    drive(0, 1, 32'hDEAD_BEEF, 16'd0);
    expect_out("zero_step", 1, 32'hDEAD_BEEF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h5555_5555, 16'h0FFF);
      expect_out("idle_hold", 0, 32'hDEAD_BEEF, 0, 0);
    end

    // Reset mid-stream
    drive(0, 1, 32'h0000_0100, 16'd1);
    expect_out("stream_100", 1, 32'h0000_0101, 0, 0);
    drive(1, 1, 32'h0000_0200, 16'd1);
    expect_out("stream_rst", 0, 32'h0, 0, 0);
    drive(0, 1, 32'h0000_0300, 16'd1);
    expect_out("stream_resume", 1, 32'h0000_0301, 0, 0);

    // Large step wrapping
    drive(0, 1, 32'hFFFF_8000, 16'h8000);
    expect_out("large_step", 1, 32'h0000_0000, 1, 1);
    drive(0, 1, 32'h0000_1000, 16'hFFFF);
    expect_out("multi_page", 1, 32'h0001_0FFF, 0, 1);

    // Randomized traffic, biased toward page edges and the top of memory
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = {$urandom_range(0, 32'hFFFFF), 12'hFFF} - 32'($urandom_range(0, 3));
        2:       a = 32'hFFFF_FFFF - 32'($urandom_range(0, 16'hFFFF));
        default: a = {$urandom_range(0, 32'hFFFFF), 12'h000};
      endcase
      case ($urandom_range(0, 3))
        0:       s = 16'd0;
        1:       s = 16'd1;
        default: s = 16'($urandom);
      endcase
      drive(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, a, s);
    end
    drive(0, 0, 32'h0, 16'h0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
